// File: rtl/mux_nway_arb_pkg.sv
// Shared constants, mode encodings and sizing helpers for the
// N-way registered mux/arbiter.
package mux_nway_arb_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_WAYS  = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Select/grant width; never below one bit.
    function automatic int sel_w(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/mux_nway_arb_if.sv
// Producer/consumer bundle for mux_nway_arb: per-channel
// valid/ready inputs, one registered valid/ready output.
interface mux_nway_arb_if
    import mux_nway_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WAYS  = DEF_WAYS
) ();

    localparam int SEL_W = sel_w(WAYS);

    logic                  mode;
    logic [SEL_W-1:0]      select;
    logic [WAYS*WIDTH-1:0] in_data;
    logic [WAYS-1:0]       in_valid;
    logic [WAYS-1:0]       in_ready;
    logic [WIDTH-1:0]      out;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_grant;

    modport master (
        output mode,
        output select,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid,
        output out_ready,
        input  out_grant
    );

    modport slave (
        input  mode,
        input  select,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid,
        input  out_ready,
        output out_grant
    );

endinterface

// File: rtl/rr_arbiter_nway.sv
// Rotating-priority picker: first eligible channel from ptr
// upward, wrapping; owns the pointer and advances it on grant.
module rr_arbiter_nway
    import mux_nway_arb_pkg::*;
#(
    parameter int WAYS = DEF_WAYS
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [WAYS-1:0]          elig_i,
    input  logic                     upd_i,
    output logic [sel_w(WAYS)-1:0]   grant_o,
    output logic                     found_o
);

    localparam int SEL_W = sel_w(WAYS);
    localparam logic [SEL_W:0] WAYS_X = (SEL_W + 1)'(WAYS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(WAYS - 1);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WAYS-1:0]  rot;
    logic [SEL_W:0]   off;
    logic [SEL_W:0]   sum;

    // Rotate so bit 0 is the channel at ptr; lowest set bit wins.
    always_comb begin
        rot     = WAYS'({elig_i, elig_i} >> ptr_q);
        off     = '0;
        found_o = 1'b0;
        for (int j = WAYS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off     = (SEL_W + 1)'(j);
                found_o = 1'b1;
            end
        end
        sum = {1'b0, ptr_q} + off;
        if (sum >= WAYS_X) sum = sum - WAYS_X;
        grant_o = sum[SEL_W-1:0];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i && found_o) begin
            ptr_d = (grant_o == LAST) ? '0 : grant_o + SEL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_nway_arb.sv
// N-way, W-bit registered mux with fixed-select or round-robin
// choice and a single-entry output register.
module mux_nway_arb
    import mux_nway_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WAYS  = DEF_WAYS
) (
    input  logic          clk,
    input  logic          reset_n,
    mux_nway_arb_if.slave bus
);

    localparam int SEL_W = sel_w(WAYS);

    logic [WIDTH-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic [SEL_W-1:0] gnt_q, gnt_d;

    logic             is_rr;
    logic             load_en;
    logic             found;
    logic             xfer;
    logic [WAYS-1:0]  elig;
    logic [SEL_W-1:0] pick;
    logic [WIDTH-1:0] chan [WAYS];

    assign is_rr   = (mode_e'(bus.mode) == MODE_RR);
    assign load_en = !vld_q || bus.out_ready;
    assign xfer    = load_en && found;

    // An out-of-range select matches no channel, so nothing is eligible.
    always_comb begin
        elig = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (is_rr) begin
                elig[i] = bus.in_valid[i];
            end else begin
                elig[i] = bus.in_valid[i]
                        && (bus.select == SEL_W'(i));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            chan[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    rr_arbiter_nway #(
        .WAYS (WAYS)
    ) u_arb (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .elig_i    (elig),
        .upd_i     (xfer && is_rr),
        .grant_o   (pick),
        .found_o   (found)
    );

    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready[pick] = 1'b1;
    end

    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        gnt_d = gnt_q;
        if (xfer) begin
            out_d = chan[pick];
            vld_d = 1'b1;
            gnt_d = pick;
        end else if (vld_q && bus.out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
            gnt_q <= '0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
            gnt_q <= gnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.out_grant = gnt_q;

endmodule

// File: tb/tb_mux_nway_arb.sv
// Directed bench for mux_nway_arb with a queue-based output scoreboard.
module tb_mux_nway_arb;
    import mux_nway_arb_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0]  g;
        logic [15:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    exp_t sb [$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_nway_arb_if #(.WIDTH(W), .WAYS(N)) bus ();

    mux_nway_arb #(.WIDTH(W), .WAYS(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input int d);
        exp_t x;
        x.g = 2'(g);
        x.d = 16'(d);
        sb.push_back(x);
    endtask

    task automatic set_data(input int base);
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 16'(base + i);
    endtask

    // Words are consumed at the next rising edge when valid&ready.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.out_valid === 1'b1
            && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h/%0d expected none",
                         bus.out, bus.out_grant);
            end else begin
                e = sb.pop_front();
                chk("sb_data", 32'(bus.out), 32'(e.d));
                chk("sb_grant", 32'(bus.out_grant), 32'(e.g));
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        bus.mode      = 1'b0;
        bus.select    = '0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_grant", 32'(bus.out_grant), 0);
        reset_n = 1'b1;
        step();

        // Fixed mode, select 2; other valid channels ignored.
        bus.mode      = MODE_FIXED;
        bus.select    = 2'd2;
        bus.in_data   = {16'h3333, 16'hBEEF, 16'h2222, 16'h1111};
        bus.in_valid  = 4'b0111;
        bus.out_ready = 1'b1;
        #1;
        chk("fix_ready", 32'(bus.in_ready), 32'h4);
        push(2, 16'hBEEF);
        step();
        chk("fix_out", 32'(bus.out), 32'hBEEF);
        chk("fix_valid", 32'(bus.out_valid), 1);
        chk("fix_grant", 32'(bus.out_grant), 2);
        bus.select = 2'd3;
        #1;
        chk("fix_noval", 32'(bus.in_ready), 0);
        step();

        // Round-robin, all valid, full throughput.
        bus.mode     = MODE_RR;
        bus.in_valid = 4'b1111;
        set_data(16'h1000);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(bus.in_ready), 32'(1 << (k % 4)));
            push(k % 4, 16'h1000 + (k % 4));
            step();
        end
        bus.in_valid = '0;
        step();

        // Stall with ptr=1: load ch1, hold 3 cycles, then ch2.
        bus.in_valid = 4'b1111;
        #1;
        chk("st_ready0", 32'(bus.in_ready), 32'h2);
        push(1, 16'h1001);
        step();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_hold_rdy", 32'(bus.in_ready), 0);
            chk("st_hold_out", 32'(bus.out), 32'h1001);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("st_resume", 32'(bus.in_ready), 32'h4);
        push(2, 16'h1002);
        step();
        bus.in_valid = '0;
        step();

        // ptr=3, only ch0/ch1 valid: wrap to ch0, then ch1.
        bus.in_valid = 4'b0011;
        #1;
        chk("wrap_ch0", 32'(bus.in_ready), 32'h1);
        push(0, 16'h1000);
        step();
        #1;
        chk("wrap_ch1", 32'(bus.in_ready), 32'h2);
        push(1, 16'h1001);
        step();
        bus.in_valid = '0;
        step();

        // ptr=2; a fixed transfer on ch3 must not move it.
        bus.mode     = MODE_FIXED;
        bus.select   = 2'd3;
        bus.in_valid = 4'b1111;
        #1;
        chk("mix_fix", 32'(bus.in_ready), 32'h8);
        push(3, 16'h1003);
        step();
        bus.mode = MODE_RR;
        #1;
        chk("mix_rr", 32'(bus.in_ready), 32'h4);
        push(2, 16'h1002);
        step();
        bus.in_valid = '0;
        step();

        // ptr=3: load ch3 and hold it, then reset asynchronously.
        bus.in_valid = 4'b1111;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = '0;
        #1;
        chk("rst_held", 32'(bus.out), 32'h1003);
        chk("rst_held_g", 32'(bus.out_grant), 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_out", 32'(bus.out), 0);
        chk("arst_grant", 32'(bus.out_grant), 0);
        step();
        reset_n       = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst", 32'(bus.in_ready), 32'h1);
        push(0, 16'h1000);
        step();
        chk("post_grant", 32'(bus.out_grant), 0);
        bus.in_valid = '0;
        repeat (3) step();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nway_arb.md
Name: mux_nway_arb

Overview:
Parametrised successor to the fixed 4-way/16-bit selectors. It is an N-way, W-bit registered multiplexer with per-channel valid/ready handshakes. It has two modes: fixed (the select port chooses the source, as the combinational muxes do) and round-robin arbitration across all valid channels. It sits between multiple producers (ALU result, memory read, I/O) and a single consumer on the datapath bus.

Parameters:
WIDTH, 16, data bits per channel (>=1)
WAYS, 4, number of input channels (>=2)
SEL_W, $clog2(WAYS), select/grant width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
mode  input  1  0 = fixed select, 1 = round-robin
select  input  SEL_W  channel index used in fixed mode
in_data  input  WAYS*WIDTH  packed channel data; channel i = in_data[i*WIDTH +: WIDTH]
in_valid  input  WAYS  per-channel data valid
in_ready  output  WAYS  per-channel accept (one-hot or zero)
out  output  WIDTH  registered output data
out_valid  output  1  out holds a word
out_ready  input  1  consumer accepts out this cycle
out_grant  output  SEL_W  index of the channel whose word is in out

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n). While reset_n=0: out=0, out_valid=0, out_grant=0, round-robin pointer=0. All changes take effect immediately, not on a clock edge.
- Single-entry output register. load_en = !out_valid | out_ready.
- Eligibility:
  - Fixed mode: only channel `select`, and only if in_valid[select]=1.
  - If select >= WAYS (non-power-of-2 WAYS), no channel is eligible.
  - Round-robin mode: every channel with in_valid=1.
- Choice (round-robin): first eligible channel scanning ptr, ptr+1, ..., wrapping modulo WAYS.
- Choice (fixed): the single eligible channel.
- in_ready[c] = load_en & eligible(c) for the chosen c only. All other in_ready bits are 0. in_ready is combinational from in_valid, mode, select, out_valid, out_ready, ptr.
- A transfer on channel c means in_valid[c] & in_ready[c]. At the next edge: out <= channel c data, out_valid <= 1, out_grant <= c.
- Latency: input handshake to out_valid is 1 cycle.
- Drain with no new transfer: if out_valid & out_ready and no transfer occurs, out_valid <= 0. out and out_grant hold their last values.
- Simultaneous drain and load: both occur in the same cycle, giving full throughput of 1 word/cycle.
- Stall: if out_valid & !out_ready, out, out_valid and out_grant are held and all in_ready=0.
- Round-robin pointer:
  - Updated only on a transfer in round-robin mode: ptr <= (c+1) mod WAYS, wrapping from WAYS-1 to 0.
  - Unchanged by fixed-mode transfers and idle cycles.
- mode and select are sampled combinationally each cycle. Changing them never disturbs a word already held in out.
- Reset asserted mid-transfer: the held word is discarded. The pointer returns to 0, so channel 0 has top priority after reset.

Decomposition:
- Shared package: default WIDTH/WAYS constants, mode encodings (MODE_FIXED=0, MODE_RR=1), clog2 helper.
- One sub-module, rr_arbiter_nway: takes the eligibility vector and ptr, returns the chosen index and a found flag. It owns the pointer register and its update-on-grant.
- The top level holds the output register and the handshake logic.

Test Plan:
- Reset then fixed mode, select=2, in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out=BEEF, out_valid=1, out_grant=2. Other channels' valids are ignored.
- Round-robin, all in_valid=1 held, out_ready=1, ch i data = 16'h1000+i -> out sequence 1000, 1001, 1002, 1003, 1000, ..., one word per cycle, grants 0,1,2,3,0.
- Round-robin, out_ready=0 after first load of ch0 -> out=1000 held, in_ready=0 for 3 cycles. Raise out_ready -> next word is ch1, with no duplicate or loss.
- Round-robin, ptr=3 after granting ch2, in_valid=4'b0011 -> ch0 granted (wrap), then ptr=1 -> ch1 granted next.
- Mid-stream: fixed mode select=1 transfer, then switch to round-robin -> ptr unchanged by the fixed transfer, so arbitration resumes from the prior ptr.
- Assert reset_n=0 asynchronously while out_valid=1 -> out_valid, out and out_grant go to 0 immediately. After release with all valid, the first grant is ch0.
